// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Frame buffer geometry, pixel type and fill FSM encoding
//                shared by the rectangle fill engine and the VGA read side.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

  localparam int unsigned H_RES    = 320;
  localparam int unsigned V_RES    = 240;
  localparam int unsigned FB_DEPTH = H_RES * V_RES;
  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned DATA_W   = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/rect_fill_engine_clip.sv
`default_nettype none
// ============================================================================
//  Module      : rect_clip
//  Description : Combinational clip of a rectangle command to the screen;
//                yields exclusive end coordinates and the first row base.
//  Revision    : 1.0  initial release
// ============================================================================
module rect_clip #(
  parameter int unsigned H_RES  = fb_pkg::H_RES,
  parameter int unsigned V_RES  = fb_pkg::V_RES,
  parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic [8:0]        w,
  input  logic [7:0]        h,
  output logic [9:0]        x_end,
  output logic [9:0]        y_end,
  output logic [ADDR_W-1:0] row_base,
  output logic              empty
);

  localparam logic [9:0] c_h_res = 10'(H_RES);
  localparam logic [9:0] c_v_res = 10'(V_RES);

  logic [9:0] w_x_sum;
  logic [9:0] w_y_sum;

  always_comb begin
    w_x_sum  = {1'b0, x} + {1'b0, w};
    w_y_sum  = {2'b0, y} + {2'b0, h};
    x_end    = (w_x_sum > c_h_res) ? c_h_res : w_x_sum;
    y_end    = (w_y_sum > c_v_res) ? c_v_res : w_y_sum;
    row_base = ADDR_W'(y) * ADDR_W'(H_RES);
    empty    = (w == 9'd0) || (h == 8'd0) ||
               ({1'b0, x} >= c_h_res) || ({2'b0, y} >= c_v_res);
  end

endmodule
`default_nettype wire

// File: rtl/rect_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rect_fill_engine
//  Description : Serialises clipped solid-colour rectangle commands into one
//                frame buffer write per cycle. Define RECT_FILL_VBLANK_GATE_EN
//                to restrict writes to vblank cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module rect_fill_engine #(
  parameter int unsigned H_RES  = fb_pkg::H_RES,
  parameter int unsigned V_RES  = fb_pkg::V_RES,
  parameter int unsigned ADDR_W = fb_pkg::ADDR_W,
  parameter int unsigned DATA_W = fb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              vblank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] c_h_res_a = ADDR_W'(H_RES);

  fill_state_t       r_state, w_state_nx;
  logic [8:0]        r_x0, r_w;
  logic [7:0]        r_y0, r_h;
  logic [DATA_W-1:0] r_color;
  logic [9:0]        r_x, r_y, r_x_end, r_y_end;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_wr_en;

  logic [9:0]        w_x_end, w_y_end;
  logic [ADDR_W-1:0] w_row_base;
  logic              w_empty, w_go, w_row_end, w_last;

  rect_clip #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_clip (
    .x        (r_x0),
    .y        (r_y0),
    .w        (r_w),
    .h        (r_h),
    .x_end    (w_x_end),
    .y_end    (w_y_end),
    .row_base (w_row_base),
    .empty    (w_empty)
  );

`ifdef RECT_FILL_VBLANK_GATE_EN
  assign w_go = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_go = 1'b1;
`endif

  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign wr_en     = r_wr_en && w_go;
  assign w_row_end = (r_x == r_x_end - 10'd1);
  assign w_last    = w_row_end && (r_y == r_y_end - 10'd1);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid) w_state_nx = ST_SETUP;
      ST_SETUP: w_state_nx = w_empty ? ST_DONE : ST_FILL;
      ST_FILL:  if (w_go && w_last) w_state_nx = ST_DONE;
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wr_en    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_color    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_row_base <= '0;
    end else begin
      r_state <= w_state_nx;
      busy    <= (w_state_nx != ST_IDLE);
      done    <= (w_state_nx == ST_DONE);
      r_wr_en <= (w_state_nx == ST_FILL);
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_x0    <= cmd_x;
            r_y0    <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
          end
        end
        ST_SETUP: begin
          // Empty commands leave the write port untouched.
          if (!w_empty) begin
            r_x_end    <= w_x_end;
            r_y_end    <= w_y_end;
            r_x        <= {1'b0, r_x0};
            r_y        <= {2'b0, r_y0};
            r_row_base <= w_row_base;
            wr_addr    <= w_row_base + ADDR_W'(r_x0);
            wr_data    <= r_color;
          end
        end
        ST_FILL: begin
          if (w_go && !w_last) begin
            if (w_row_end) begin
              r_x        <= {1'b0, r_x0};
              r_y        <= r_y + 10'd1;
              r_row_base <= r_row_base + c_h_res_a;
              wr_addr    <= r_row_base + c_h_res_a + ADDR_W'(r_x0);
            end else begin
              r_x     <= r_x + 10'd1;
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_fill_engine
//  Description : Self-checking bench for rect_fill_engine with a per-command
//                write-list model and directed rectangle commands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rect_fill_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [15:0] cmd_color;
  logic        vblank;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;

  rect_fill_engine dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .vblank    (vblank),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the full list of on-screen pixels of the accepted command.
  int          exp_q[$];
  int          got_q[$];
  int          exp_n      = 0;
  int          cmd_writes = 0;
  int          acc_cyc    = 0;
  int          done_cyc   = 0;
  int          done_cnt   = 0;
  logic [15:0] exp_color  = '0;
  bit          pending    = 1'b0;
  bit          toggle_en  = 1'b0;

  always @(negedge clk) begin
    if (cyc > 1) begin
      chk("busy", busy, pending);
      if (wr_en) begin
        got_q.push_back(int'(wr_addr));
        chk("addr_in_fb", (wr_addr < 17'd76800), 1);
`ifdef RECT_FILL_VBLANK_GATE_EN
        chk("write_in_vblank", vblank, 1);
`endif
        if (!pending || exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          if (cmd_writes == 0 && !toggle_en) chk("first_write_cycle", cyc, acc_cyc + 2);
          chk("wr_addr", wr_addr, exp_q.pop_front());
          chk("wr_data", wr_data, exp_color);
          cmd_writes++;
        end
      end
      if (done) begin
        chk("done_pending", pending, 1);
        chk("done_writes", cmd_writes, exp_n);
        if (!toggle_en) chk("done_cycle", cyc, acc_cyc + 2 + exp_n);
        pending  = 1'b0;
        done_cyc = cyc;
        done_cnt++;
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.delete();
        exp_n = 0;
        for (int yy = int'(cmd_y); yy < int'(cmd_y) + int'(cmd_h); yy++)
          for (int xx = int'(cmd_x); xx < int'(cmd_x) + int'(cmd_w); xx++)
            if (xx < 320 && yy < 240) begin
              exp_q.push_back(yy * 320 + xx);
              exp_n++;
            end
        exp_color  = cmd_color;
        acc_cyc    = cyc;
        cmd_writes = 0;
        pending    = 1'b1;
      end
      if (rst) begin
        exp_q.delete();
        pending = 1'b0;
      end
    end
  end

`ifdef RECT_FILL_VBLANK_GATE_EN
  initial begin
    int t = 0;
    forever begin
      @(posedge clk);
      if (toggle_en) begin
        t++;
        if (t % 2 == 0) begin
          #1 vblank = ~vblank;
        end
      end
    end
  end
`endif

  task automatic issue(input int x, input int y, input int w, input int h,
                       input logic [15:0] c, input bit hold);
    int k = 0;
    @(posedge clk); #1;
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
    cmd_color = c; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int k = 0;
    while (done_cnt == start && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    if (done_cnt == start) chk("done_timeout", 1, 0);
  endtask

  task automatic chk_got(input string name, input int exp[]);
    chk({name, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk(name, got_q[i], exp[i]);
  endtask

  initial begin
    int a;
    int d;
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
`ifdef RECT_FILL_VBLANK_GATE_EN
    vblank = 1'b1;
`else
    vblank = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_ready_in_rst", cmd_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    // 2x2 at origin
    got_q.delete();
    issue(0, 0, 2, 2, 16'hF800, 1'b0);
    a = acc_cyc;
    wait_done(40);
    chk_got("t1_addr", '{0, 1, 320, 321});
    chk("t1_total", done_cyc - a, 6);
    @(negedge clk);
    chk("t1_ready_after", cmd_ready, 1);

    // bottom-right corner clip
    got_q.delete();
    issue(318, 239, 5, 4, 16'h07E0, 1'b0);
    wait_done(40);
    chk_got("t2_addr", '{76798, 76799});

    // right-edge clip over two rows
    got_q.delete();
    issue(315, 100, 10, 2, 16'h001F, 1'b0);
    wait_done(40);
    chk_got("t2b_addr", '{32315, 32316, 32317, 32318, 32319,
                          32635, 32636, 32637, 32638, 32639});

    // empty commands: zero width, then off-screen x
    got_q.delete();
    issue(5, 5, 0, 3, 16'h1234, 1'b0);
    a = acc_cyc;
    wait_done(20);
    chk("t3_done_at", done_cyc - a, 2);
    @(negedge clk);
    chk("t3_ready_at", cyc - a, 3);
    chk("t3_ready", cmd_ready, 1);
    issue(400, 10, 4, 4, 16'h4321, 1'b0);
    a = acc_cyc;
    wait_done(20);
    chk("t3b_done_at", done_cyc - a, 2);
    chk("t3_writes", got_q.size(), 0);

    // cmd_valid held through a 3x1 fill with a different command presented
    got_q.delete();
    issue(10, 5, 3, 1, 16'hAAAA, 1'b1);
    cmd_x = 9'd100; cmd_y = 8'd1; cmd_w = 9'd1; cmd_h = 8'd2; cmd_color = 16'h5555;
    wait_done(40);
    d = done_cyc;
    chk("t4_first_writes", got_q.size(), 3);
    begin
      int k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    chk("t4_second_accept", acc_cyc, d + 1);
    wait_done(40);
    chk_got("t4_addr", '{1610, 1611, 1612, 420, 740});

    // reset on the second write of a 4x4
    got_q.delete();
    issue(20, 10, 4, 4, 16'hBEEF, 1'b0);
    a = acc_cyc;
    while (cyc < a + 3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_wr_en", wr_en, 0);
    chk("t5_done", done, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_wr_addr", wr_addr, 0);
    d = done_cnt;
    repeat (4) @(negedge clk);
    chk("t5_no_done", done_cnt, d);
    chk_got("t5_addr", '{3220, 3221});
    got_q.delete();
    issue(5, 5, 2, 1, 16'hC0DE, 1'b0);
    wait_done(40);
    chk_got("t5b_addr", '{1605, 1606});

`ifdef RECT_FILL_VBLANK_GATE_EN
    // 4x1 with vblank toggling every two cycles
    got_q.delete();
    toggle_en = 1'b1;
    issue(50, 20, 4, 1, 16'h0F0F, 1'b0);
    wait_done(80);
    toggle_en = 1'b0;
    @(posedge clk); #1 vblank = 1'b1;
    chk_got("t6_addr", '{6450, 6451, 6452, 6453});
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
